// File: rtl/ddp_tx_segmenter_if.sv
// ddp_tx_segmenter_if: RDMAP header strobe input and DDP header word stream toward the framer.
interface ddp_tx_segmenter_if;
    logic        hdr_valid;
    logic [55:0] hdr;
    logic [7:0]  ctrl;
    logic        tx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    modport master (input hdr_valid, hdr, ctrl, tx_ready, output tx_valid, tx_data, tx_sop, tx_eop);
    modport slave (output hdr_valid, hdr, ctrl, tx_ready, input tx_valid, tx_data, tx_sop, tx_eop);
endinterface

// File: rtl/ddp_tx_segmenter.sv
// ddp_tx_segmenter: buffers RDMAP headers and emits a 3-word DDP header per MULPDU-sized segment.
// Defining DDP_TX_STATS_EN adds segment/message counter outputs.
module ddp_tx_segmenter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MULPDU     = 1024,
    parameter int QN_BITS    = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    ddp_tx_segmenter_if.master          io_ddp,
    output logic                        o_hdr_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_hdr_fifo_depth
`ifdef DDP_TX_STATS_EN
    ,
    output logic [31:0]                 o_seg_count,
    output logic [31:0]                 o_msg_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] MPDU = 16'(MULPDU);
    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;
    state_t        r_state;
    state_t        w_next;
    logic [60:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_msn [2**QN_BITS];
    logic [7:0]    r_qn;
    logic [31:0]   r_stag;
    logic [3:0]    r_op;
    logic          r_t;
    logic [15:0]   r_remain;
    logic [31:0]   r_seg_off;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic          w_last;
    logic          w_seg_done;
    logic [15:0]   w_seg_len;
    logic [60:0]   w_head;
    logic          w_unused;

    assign w_unused = ^io_ddp.ctrl[7:5];
    assign w_full = r_count == FULL_CNT;
    assign w_empty = r_count == '0;
    assign w_accept = io_ddp.tx_valid && io_ddp.tx_ready;
    assign w_last = r_remain <= MPDU;
    assign w_seg_len = w_last ? r_remain : MPDU;
    assign w_seg_done = r_state == W2 && w_accept;
    // The head entry stays in the FIFO until its final segment is accepted.
    assign w_pop = w_seg_done && w_last;
    assign w_push = io_ddp.hdr_valid && (!w_full || w_pop);
    assign w_head = r_mem[r_rd_ptr];
    assign o_hdr_fifo_depth = r_count;

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= {io_ddp.ctrl[4:0], io_ddp.hdr};
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count <= '0;
            o_hdr_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) r_count <= r_count + (AW + 1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW + 1)'(1);
            if (io_ddp.hdr_valid && w_full && !w_pop) o_hdr_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_empty ? IDLE : W0;
            W0: w_next = w_accept ? W1 : W0;
            W1: w_next = w_accept ? W2 : W1;
            W2: w_next = !w_accept ? W2 : (w_last ? IDLE : W0);
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        io_ddp.tx_valid = r_state != IDLE;
        io_ddp.tx_sop = r_state == W0;
        io_ddp.tx_eop = r_state == W2;
        io_ddp.tx_data = r_state == W0 ? {w_last, r_t, 2'b00, r_op, r_qn, w_seg_len} :
                         r_state == W1 ? (r_t ? r_stag : r_msn[r_qn[QN_BITS-1:0]]) :
                         r_state == W2 ? r_seg_off : 32'd0;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_qn <= '0;
            r_stag <= '0;
            r_op <= '0;
            r_t <= 1'b0;
            r_remain <= '0;
            r_seg_off <= '0;
            for (int i = 0; i < 2**QN_BITS; i++) r_msn[i] <= 32'd1;
        end else if (r_state == IDLE && !w_empty) begin
            r_t <= w_head[60];
            r_op <= w_head[59:56];
            r_qn <= w_head[55:48];
            r_remain <= w_head[47:32];
            r_stag <= w_head[31:0];
            r_seg_off <= '0;
        end else if (w_seg_done) begin
            if (!w_last) begin
                r_remain <= r_remain - w_seg_len;
                r_seg_off <= r_seg_off + {16'd0, w_seg_len};
            end else if (!r_t) begin
                r_msn[r_qn[QN_BITS-1:0]] <= r_msn[r_qn[QN_BITS-1:0]] + 32'd1;
            end
        end
    end

`ifdef DDP_TX_STATS_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_seg_count <= '0;
            o_msg_count <= '0;
        end else if (w_seg_done) begin
            o_seg_count <= o_seg_count + 32'd1;
            if (w_last) o_msg_count <= o_msg_count + 32'd1;
        end
    end
`endif
endmodule
